// File: rtl/gesummv_row_feeder_if.sv
// Host/consumer-facing bundle for gesummv_row_feeder: operand write port,
// start strobe, and the packed row stream with its valid/ready handshake.
interface gesummv_row_feeder_if;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [3:0]  wr_row;
    logic [15:0] wr_data;
    logic        start;
    logic        out_ready;

    logic        out_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] X;
    logic [3:0]  c;
    logic [3:0]  v;
    logic [3:0]  out_row;
    logic        busy;
    logic        done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_data, start, out_ready,
        input  out_valid, A, B, X, c, v, out_row, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_data, start, out_ready,
        output out_valid, A, B, X, c, v, out_row, busy, done
    );
endinterface

// File: rtl/gesummv_row_feeder.sv
// GESUMMV operand store and row streamer: holds A, B (ROWS x 4 nibbles), X, c, v
// and replays one packed row per accepted beat. Optional macro: GESUMMV_FEEDER_HOLD_EN.
module gesummv_row_feeder #(
    parameter int ROWS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gesummv_row_feeder_if.slave  bus
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

`ifdef GESUMMV_FEEDER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_A   = 2'd0,
        SEL_B   = 2'd1,
        SEL_X   = 2'd2,
        SEL_SCL = 2'd3
    } wr_sel_t;

    state_t state_q;
    state_t state_d;

    // Operand storage
    logic [15:0] a_mem [ROWS];
    logic [15:0] b_mem [ROWS];
    logic [15:0] x_reg;
    logic [3:0]  c_reg;
    logic [3:0]  v_reg;

    // Registered outputs
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  row_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] x_q;
    logic [3:0]  c_q;
    logic [3:0]  v_q;

    // Control strobes decoded from the current state
    logic        accept;
    logic        last_beat;
    logic        do_write;
    logic        load_first;
    logic        advance;
    logic        finish;

    logic [3:0]  rd_idx;
    logic [15:0] rd_a;
    logic [15:0] rd_b;

    assign accept    = valid_q & bus.out_ready;
    assign last_beat = (row_q == LAST_ROW);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.wr_en && bus.start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output/control decode
    // ------------------------------------------------------------------
    always_comb begin
        do_write   = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            IDLE: begin
                do_write   = bus.wr_en;
                load_first = !bus.wr_en && bus.start;
            end
            STREAM: begin
                advance = accept && !last_beat;
                finish  = accept && last_beat;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand storage; out-of-range row writes match no entry and are dropped
    // ------------------------------------------------------------------
    // NOTE: the operand arrays are deliberately reset: a reset must leave the
    // block streaming zeros, not whatever was loaded before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                a_mem[r] <= '0;
                b_mem[r] <= '0;
            end
            x_reg <= '0;
            c_reg <= '0;
            v_reg <= '0;
        end else if (do_write) begin
            case (wr_sel_t'(bus.wr_sel))
                SEL_A: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (bus.wr_row == 4'(r)) begin
                            a_mem[r] <= bus.wr_data;
                        end
                    end
                end
                SEL_B: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (bus.wr_row == 4'(r)) begin
                            b_mem[r] <= bus.wr_data;
                        end
                    end
                end
                SEL_X: x_reg <= bus.wr_data;
                SEL_SCL: begin
                    c_reg <= bus.wr_data[7:4];
                    v_reg <= bus.wr_data[3:0];
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Row read mux: row 0 on the start edge, otherwise the row after the
    // one being accepted
    // ------------------------------------------------------------------
    assign rd_idx = load_first ? 4'd0 : row_q + 4'd1;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rd_idx == 4'(r)) begin
                rd_a = a_mem[r];
                rd_b = b_mem[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers; X, c, v are captured once per stream at start
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            row_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            c_q     <= '0;
            v_q     <= '0;
        end else begin
            valid_q <= (state_d == STREAM);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (load_first) begin
                a_q   <= rd_a;
                b_q   <= rd_b;
                x_q   <= x_reg;
                c_q   <= c_reg;
                v_q   <= v_reg;
                row_q <= '0;
            end else if (advance) begin
                a_q   <= rd_a;
                b_q   <= rd_b;
                row_q <= rd_idx;
            end else if (finish && !HOLD_EN) begin
                // Compute stage samples every clock; zero data yields Y = 0
                a_q <= '0;
                b_q <= '0;
                x_q <= '0;
                c_q <= '0;
                v_q <= '0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_row   = row_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.X         = x_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;

endmodule

// File: tb/tb_gesummv_row_feeder.sv
// Directed bench for gesummv_row_feeder (ROWS = 4): a reference model of the
// operand store feeds a beat scoreboard that is drained as the DUT's beats are accepted.
module tb_gesummv_row_feeder;

    localparam int ROWS = 4;

`ifdef GESUMMV_FEEDER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] x;
        logic [3:0]  c;
        logic [3:0]  v;
        logic [3:0]  row;
    } beat_t;

    logic clk;
    logic rst_n;

    gesummv_row_feeder_if ifc ();

    gesummv_row_feeder #(.ROWS(ROWS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    beat_t       sb_q[$];
    beat_t       exp_idle;
    logic [15:0] a_m [ROWS];
    logic [15:0] b_m [ROWS];
    logic [15:0] x_m;
    logic [3:0]  c_m;
    logic [3:0]  v_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            a_m[r] = '0;
            b_m[r] = '0;
        end
        x_m = '0;
        c_m = '0;
        v_m = '0;
        exp_idle = '{a: '0, b: '0, x: '0, c: '0, v: '0, row: '0};
    endtask

    // Score the presented beat if it is accepted at the coming edge, then advance.
    task automatic tick();
        beat_t e;
        if (ifc.out_ready && ifc.out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {31'b0, ifc.out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("beat_A",   {16'b0, ifc.A}, {16'b0, e.a});
                check("beat_B",   {16'b0, ifc.B}, {16'b0, e.b});
                check("beat_X",   {16'b0, ifc.X}, {16'b0, e.x});
                check("beat_c",   {28'b0, ifc.c}, {28'b0, e.c});
                check("beat_v",   {28'b0, ifc.v}, {28'b0, e.v});
                check("beat_row", {28'b0, ifc.out_row}, {28'b0, e.row});
                check("beat_no_done", {31'b0, ifc.done}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] sel, input logic [3:0] row,
                              input logic [15:0] data, input bit with_start);
        ifc.wr_en   = 1'b1;
        ifc.wr_sel  = sel;
        ifc.wr_row  = row;
        ifc.wr_data = data;
        ifc.start   = with_start;
        tick();
        ifc.wr_en = 1'b0;
        ifc.start = 1'b0;
        case (sel)
            2'd0: if (row < ROWS) a_m[row] = data;
            2'd1: if (row < ROWS) b_m[row] = data;
            2'd2: x_m = data;
            default: begin
                c_m = data[7:4];
                v_m = data[3:0];
            end
        endcase
    endtask

    task automatic check_idle_data(input string tag);
        check({tag, "_A"}, {16'b0, ifc.A}, {16'b0, exp_idle.a});
        check({tag, "_B"}, {16'b0, ifc.B}, {16'b0, exp_idle.b});
        check({tag, "_X"}, {16'b0, ifc.X}, {16'b0, exp_idle.x});
        check({tag, "_c"}, {28'b0, ifc.c}, {28'b0, exp_idle.c});
        check({tag, "_v"}, {28'b0, ifc.v}, {28'b0, exp_idle.v});
    endtask

    task automatic push_stream();
        beat_t e;
        for (int k = 0; k < ROWS; k++) begin
            e.a   = a_m[k];
            e.b   = b_m[k];
            e.x   = x_m;
            e.c   = c_m;
            e.v   = v_m;
            e.row = 4'(k);
            sb_q.push_back(e);
        end
        if (HOLD_EN) exp_idle = e;
        else exp_idle = '{a: '0, b: '0, x: '0, c: '0, v: '0, row: '0};
    endtask

    // Full stream; optional stall on one row and an illegal write/start poke on row 1.
    task automatic run_stream(input int stall_row, input int stall_cycles, input bit poke);
        ifc.out_ready = 1'b1;
        ifc.start     = 1'b1;
        push_stream();
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        check("start_valid", {31'b0, ifc.out_valid}, 32'd1);
        check("start_busy",  {31'b0, ifc.busy}, 32'd1);
        for (int k = 0; k < ROWS; k++) begin
            check("row_valid", {31'b0, ifc.out_valid}, 32'd1);
            if (k == stall_row) begin
                ifc.out_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check("stall_A",   {16'b0, ifc.A}, {16'b0, sb_q[0].a});
                    check("stall_row", {28'b0, ifc.out_row}, 32'(k));
                    tick();
                end
                ifc.out_ready = 1'b1;
            end
            if (poke && k == 1) begin
                ifc.wr_en   = 1'b1;
                ifc.wr_sel  = 2'd0;
                ifc.wr_row  = 4'd0;
                ifc.wr_data = 16'hFFFF;
                ifc.start   = 1'b1;
            end
            tick();
            ifc.wr_en = 1'b0;
            ifc.start = 1'b0;
        end
        check("sb_drained",    32'(sb_q.size()), 32'd0);
        check("done_pulse",    {31'b0, ifc.done}, 32'd1);
        check("done_no_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("done_busy",     {31'b0, ifc.busy}, 32'd1);
        check_idle_data("after_last");
        tick();
        check("done_single", {31'b0, ifc.done}, 32'd0);
        check("idle_busy",   {31'b0, ifc.busy}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b1;
        ifc.wr_en     = 1'b0;
        ifc.wr_sel    = '0;
        ifc.wr_row    = '0;
        ifc.wr_data   = '0;
        ifc.start     = 1'b0;
        ifc.out_ready = 1'b0;
        model_reset();

        // Reset values, during and after reset
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("rst_busy",  {31'b0, ifc.busy}, 32'd0);
        check_idle_data("rst");
        rst_n = 1'b1;
        tick();
        check("post_rst_done", {31'b0, ifc.done}, 32'd0);
        check("post_rst_row",  {28'b0, ifc.out_row}, 32'd0);
        check_idle_data("post_rst");

        // Operand load; one out-of-range A row; X written together with start
        for (int k = 0; k < ROWS; k++) begin
            host_write(2'd0, 4'(k), {4'(k), 4'(k + 1), 4'(k + 2), 4'(k + 3)}, 1'b0);
            host_write(2'd1, 4'(k), {4'(k + 1), 4'(k + 2), 4'(k + 3), 4'(k + 4)}, 1'b0);
        end
        host_write(2'd0, 4'd4, 16'hFFFF, 1'b0);
        host_write(2'd3, 4'd0, 16'h00BB, 1'b0);
        host_write(2'd2, 4'd0, 16'h0123, 1'b1);
        check("wr_start_busy",  {31'b0, ifc.busy}, 32'd0);
        check("wr_start_valid", {31'b0, ifc.out_valid}, 32'd0);

        // Plain stream, then one with backpressure on row 1 and an ignored write
        run_stream(-1, 0, 1'b0);
        run_stream(1, 3, 1'b1);
        run_stream(-1, 0, 1'b0);
        repeat (3) tick();
        check_idle_data("idle_hold");

        // Reset mid-stream while row 2 is presented
        ifc.out_ready = 1'b1;
        ifc.start     = 1'b1;
        push_stream();
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        check("pre_abort_row", {28'b0, ifc.out_row}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("abort_busy",  {31'b0, ifc.busy}, 32'd0);
        sb_q.delete();
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", {31'b0, ifc.done}, 32'd0);
            tick();
        end

        // Storage was cleared by reset: the next stream carries zeros
        run_stream(-1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
